// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage
//  Description : RISC-V instruction decode with 32 x XLEN register file
//                (write-first bypass from writeback), load-use hazard
//                detection, and the ID/EX pipeline register. Includes a
//                saturating load-use stall counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_stage #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       InstrD,
    input  logic [XLEN-1:0]   PCD,
    input  logic [XLEN-1:0]   PCPlus4D,
    input  logic              ValidD,
    input  logic              RegWriteW,
    input  logic [4:0]        RDW,
    input  logic [XLEN-1:0]   ResultW,
    input  logic              FlushE,
    output logic              StallD,
    output logic              ValidE,
    output logic              RegWriteE,
    output logic              ALUSrcE,
    output logic              MemWriteE,
    output logic              ResultSrcE,
    output logic              BranchE,
    output logic              IllegalE,
    output logic [2:0]        ALUControlE,
    output logic [XLEN-1:0]   RD1_E,
    output logic [XLEN-1:0]   RD2_E,
    output logic [XLEN-1:0]   Imm_Ext_E,
    output logic [XLEN-1:0]   PCE,
    output logic [XLEN-1:0]   PCPlus4E,
    output logic [4:0]        RS1_E,
    output logic [4:0]        RS2_E,
    output logic [4:0]        RD_E,
    output logic [CNT_W-1:0]  StallCount
);

    localparam logic [6:0] c_OP_LW   = 7'b0000011;
    localparam logic [6:0] c_OP_SW   = 7'b0100011;
    localparam logic [6:0] c_OP_R    = 7'b0110011;
    localparam logic [6:0] c_OP_IALU = 7'b0010011;
    localparam logic [6:0] c_OP_BEQ  = 7'b1100011;

    localparam logic [2:0] c_ALU_ADD = 3'b000;
    localparam logic [2:0] c_ALU_SUB = 3'b001;
    localparam logic [2:0] c_ALU_AND = 3'b010;
    localparam logic [2:0] c_ALU_OR  = 3'b011;
    localparam logic [2:0] c_ALU_SLT = 3'b101;

    // Instruction fields
    logic [6:0] w_opcode;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic [4:0] w_rd;
    logic [2:0] w_funct3;
    logic       w_funct7b5;

    assign w_opcode   = InstrD[6:0];
    assign w_rd       = InstrD[11:7];
    assign w_funct3   = InstrD[14:12];
    assign w_rs1      = InstrD[19:15];
    assign w_rs2      = InstrD[24:20];
    assign w_funct7b5 = InstrD[30];

    // Decoded controls (before ValidD gating)
    logic            w_reg_write;
    logic            w_alu_src;
    logic            w_mem_write;
    logic            w_result_src;
    logic            w_branch;
    logic            w_illegal;
    logic            w_uses_rs2;
    logic [2:0]      w_alu_ctl;
    logic [XLEN-1:0] w_imm;

    // Register file and read ports
    logic [XLEN-1:0] r_rf [32];
    logic [XLEN-1:0] w_rd1;
    logic [XLEN-1:0] w_rd2;
    logic            w_wb_active;

    // Opcode decode, ALU-operation selection and immediate generation
    always_comb begin
        w_reg_write  = 1'b0;
        w_alu_src    = 1'b0;
        w_mem_write  = 1'b0;
        w_result_src = 1'b0;
        w_branch     = 1'b0;
        w_illegal    = 1'b0;
        w_uses_rs2   = 1'b0;
        w_alu_ctl    = c_ALU_ADD;
        w_imm        = '0;
        unique case (w_opcode)
            c_OP_LW: begin
                w_reg_write  = 1'b1;
                w_alu_src    = 1'b1;
                w_result_src = 1'b1;
                w_imm        = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
            end
            c_OP_SW: begin
                w_mem_write = 1'b1;
                w_alu_src   = 1'b1;
                w_uses_rs2  = 1'b1;
                w_imm       = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            end
            c_OP_R, c_OP_IALU: begin
                w_reg_write = 1'b1;
                w_alu_src   = (w_opcode == c_OP_IALU);
                w_uses_rs2  = (w_opcode == c_OP_R);
                if (w_opcode == c_OP_IALU) begin
                    w_imm = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
                end
                // funct7[5] selects subtract only for register-register ops;
                // on addi the same bit is just part of the immediate
                case (w_funct3)
                    3'b000:  w_alu_ctl = (w_opcode == c_OP_R && w_funct7b5) ? c_ALU_SUB : c_ALU_ADD;
                    3'b010:  w_alu_ctl = c_ALU_SLT;
                    3'b110:  w_alu_ctl = c_ALU_OR;
                    3'b111:  w_alu_ctl = c_ALU_AND;
                    default: w_alu_ctl = c_ALU_ADD;
                endcase
            end
            c_OP_BEQ: begin
                w_branch   = 1'b1;
                w_uses_rs2 = 1'b1;
                w_alu_ctl  = c_ALU_SUB;
                w_imm      = {{(XLEN-13){InstrD[31]}}, InstrD[31], InstrD[7],
                              InstrD[30:25], InstrD[11:8], 1'b0};
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    assign w_wb_active = RegWriteW && (RDW != 5'd0);

    // Register reads: x0 is hard zero, a same-cycle writeback wins over the array
    always_comb begin
        w_rd1 = '0;
        w_rd2 = '0;
        if (w_rs1 != 5'd0) begin
            w_rd1 = (w_wb_active && RDW == w_rs1) ? ResultW : r_rf[w_rs1];
        end
        if (w_rs2 != 5'd0) begin
            w_rd2 = (w_wb_active && RDW == w_rs2) ? ResultW : r_rf[w_rs2];
        end
    end

    // Register file write; reset clears every entry and drops a pending write
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                r_rf[i] <= '0;
            end
        end else if (w_wb_active) begin
            r_rf[RDW] <= ResultW;
        end
    end

    // Load in E whose destination feeds a source of D; a flush kills the load-use pair
    assign StallD = ValidE && ResultSrcE && (RD_E != 5'd0) && ValidD && !FlushE &&
                    ((RD_E == w_rs1) || (w_uses_rs2 && (RD_E == w_rs2)));

    // ID/EX register: reset, flush and stall all leave an all-zero bubble
    always_ff @(posedge clk) begin
        if (!rst || FlushE || StallD) begin
            ValidE      <= 1'b0;
            RegWriteE   <= 1'b0;
            ALUSrcE     <= 1'b0;
            MemWriteE   <= 1'b0;
            ResultSrcE  <= 1'b0;
            BranchE     <= 1'b0;
            IllegalE    <= 1'b0;
            ALUControlE <= 3'b000;
            RD1_E       <= '0;
            RD2_E       <= '0;
            Imm_Ext_E   <= '0;
            PCE         <= '0;
            PCPlus4E    <= '0;
            RS1_E       <= 5'd0;
            RS2_E       <= 5'd0;
            RD_E        <= 5'd0;
        end else begin
            ValidE      <= ValidD;
            RegWriteE   <= ValidD && w_reg_write;
            ALUSrcE     <= ValidD && w_alu_src;
            MemWriteE   <= ValidD && w_mem_write;
            ResultSrcE  <= ValidD && w_result_src;
            BranchE     <= ValidD && w_branch;
            IllegalE    <= ValidD && w_illegal;
            ALUControlE <= ValidD ? w_alu_ctl : 3'b000;
            RD1_E       <= w_rd1;
            RD2_E       <= w_rd2;
            Imm_Ext_E   <= w_imm;
            PCE         <= PCD;
            PCPlus4E    <= PCPlus4D;
            RS1_E       <= w_rs1;
            RS2_E       <= w_rs2;
            RD_E        <= w_rd;
        end
    end

    // Saturating count of load-use stall cycles
    always_ff @(posedge clk) begin
        if (!rst) begin
            StallCount <= '0;
        end else if (StallD && (StallCount != {CNT_W{1'b1}})) begin
            StallCount <= StallCount + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: doc/decode_stage.md
# decode_stage

Parametrised instruction-decode stage with integrated ID/EX pipeline register for the pipelined RISC-V core. It decodes the instruction in D, reads a 32-entry register file with write-first bypass from writeback, and detects load-use hazards, raising a stall toward fetch while inserting a bubble into E. It also accepts a flush from branch resolution. It sits between the fetch stage's IF/ID register and the execute stage, and exposes a saturating stall counter for performance monitoring.

## Interface
- XLEN, 64, datapath width: PC, register and immediate width
- CNT_W, 16, width of the load-use stall counter
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-low reset
- InstrD  in  32  instruction in D
- PCD, PCPlus4D  in  XLEN  PC and PC+4 of the instruction in D
- ValidD  in  1  D holds a real instruction
- RegWriteW  in  1  writeback enable
- RDW  in  5  writeback destination
- ResultW  in  XLEN  writeback data
- FlushE  in  1  branch taken in E; kill the instruction entering E
- StallD  out  1  hold PC and IF/ID (combinational)
- ValidE, RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, IllegalE  out  1 each  registered controls
- ALUControlE  out  3  ALU operation
- RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E  out  XLEN  registered operands, immediate and PCs
- RS1_E, RS2_E, RD_E  out  5  registered register indices
- StallCount  out  CNT_W  number of load-use stall cycles since reset, saturating

## Operation
- Opcode decode:
  - 0000011 lw: RegWrite, ALUSrc, ResultSrc, I-immediate
  - 0100011 sw: MemWrite, ALUSrc, S-immediate
  - 0110011 R-type: RegWrite
  - 0010011 I-ALU: RegWrite, ALUSrc, I-immediate
  - 1100011 beq: Branch, B-immediate
  - Any other opcode: all controls 0, IllegalE=1
- ALUControl: lw/sw → 000 add; beq → 001 sub. R and I types use funct3: 000 add (sub 001 when R-type with funct7[5]=1), 010 slt→101, 110 or→011, 111 and→010. Any other funct3 → 000.
- Immediates are sign-extended from bit 31 to XLEN. The B-immediate has bit 0 = 0.
- Register file, 32 × XLEN:
  - x0 always reads 0 and ignores writes.
  - Write occurs at the clock edge when RegWriteW=1.
  - Read bypass: when RegWriteW=1, RDW≠0 and RDW equals the read index, RD1/RD2 return ResultW in the same cycle.
- Load-use hazard: StallD=1 when all of the following hold:
  - ValidE=1, ResultSrcE=1, RD_E≠0
  - ValidD=1
  - RD_E equals rs1, or equals rs2 for an instruction that reads rs2 (sw, R-type, beq)
  - FlushE=0
- E register update, in priority order:
  1. rst=0 → all zero
  2. FlushE=1 → bubble
  3. StallD=1 → bubble
  4. Otherwise, load decode results; ValidE=ValidD. When ValidD=0, all controls load 0.
- Bubble: ValidE and all control bits 0; data/index fields don't-care but forced to 0.
- StallCount increments by 1 on each clock with StallD=1 and rst=1. It holds at 2^CNT_W−1.

## Timing
- Decode → E outputs: 1-cycle latency, registered at the rising clk edge.
- StallD is combinational from InstrD/ValidD and the E register, and is valid in the same cycle.
- A stall lasts exactly one cycle per load-use pair. On the following cycle E holds a bubble, so StallD drops.
- FlushE suppresses StallD in the same cycle.
- Reset: in the cycle after rst=0 is sampled, all E outputs, StallCount and every register-file entry are 0.
  - StallD is 0 during reset, because ValidE=0.
  - rst asserted mid-stall clears the E register and the counter. Pending bypass writes are dropped.
- Simultaneous writeback and read of the same register return the new value (bypass). A write to x0 has no effect.

## Test plan
- Reset, then `addi x1,x0,5` (0x00500093) with ValidD=1 → next cycle ValidE=1, RegWriteE=1, ALUSrcE=1, Imm_Ext_E=5, RD_E=1, RD1_E=0.
- RegWriteW=1, RDW=3, ResultW=0xAB while `add x4,x3,x3` is in D → RD1_E=RD2_E=0xAB in E (bypass). Then RDW=0 with ResultW=0xFF: reading x0 returns 0.
- `lw x2,0(x1)` followed by `add x5,x2,x1` → StallD=1 for exactly one cycle, then a bubble in E (ValidE=0, RegWriteE=0), then add enters E. StallCount=1.
- Load-use pair with FlushE=1 in the hazard cycle → StallD=0, E gets a bubble, StallCount unchanged.
- Opcode 0x7F in D → IllegalE=1 and all other controls 0. beq with imm −8 → Imm_Ext_E = all-ones…1000 (−8), ALUControlE=001.
- With CNT_W=2, four back-to-back load-use stalls → StallCount saturates at 3. Then rst=0 for one cycle → StallCount=0, ValidE=0, registers read 0.
